// File: rtl/uart_rx_if.sv
// Byte-side and line-side signals of the UART receiver.
// The receiver uses the slave modport; the host/driver side uses the master modport.
interface uart_rx_if #(
  parameter int PAYLOAD_BITS = 8
);
  logic                    uart_rxd;
  logic                    uart_rx_en;
  logic                    uart_rx_break;
  logic                    uart_rx_valid;
  logic [PAYLOAD_BITS-1:0] uart_rx_data;

  modport slave  (input  uart_rxd, uart_rx_en,
                  output uart_rx_break, uart_rx_valid, uart_rx_data);
  modport master (output uart_rxd, uart_rx_en,
                  input  uart_rx_break, uart_rx_valid, uart_rx_data);
endinterface

// File: rtl/uart_rx_unit.sv
// Asynchronous serial receiver (8N1 default, LSB first) with break detection.
// Define UART_RX_MAJORITY_EN to take each bit as a 2-of-3 vote around mid-bit.
module uart_rx_unit #(
  parameter int BIT_RATE     = 9600,
  parameter int CLK_HZ       = 48000000,
  parameter int PAYLOAD_BITS = 8,
  parameter int STOP_BITS    = 1
) (
  input  logic     clk,
  input  logic     reset,
  uart_rx_if.slave rx
);
  localparam int CYCLES_PER_BIT = CLK_HZ / BIT_RATE;
  localparam int HALF_BIT       = CYCLES_PER_BIT / 2;
  localparam int CNT_W          = $clog2(CYCLES_PER_BIT + 1);
  localparam int IDX_W          = (PAYLOAD_BITS > 1) ? $clog2(PAYLOAD_BITS) : 1;
  localparam int SB_W           = $clog2(STOP_BITS + 1);
`ifdef UART_RX_MAJORITY_EN
  localparam int START_AT       = HALF_BIT + 1;
`else
  localparam int START_AT       = HALF_BIT;
`endif
  // After the start decision the counter restarts, so every later decision is one full bit on.
  localparam int BIT_AT         = CYCLES_PER_BIT - 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic [1:0]              sync_q, sync_d;
  logic                    prev_q, prev_d;
  logic [1:0]              state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [SB_W-1:0]         stop_q, stop_d;
  logic [PAYLOAD_BITS-1:0] sr_q, sr_d;
  logic [PAYLOAD_BITS-1:0] data_q, data_d;
  logic                    valid_q, valid_d;
  logic                    brk_q, brk_d;
  logic                    rxd_s, bit_s;

  assign rxd_s = sync_q[1];

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] hist_q, hist_d;
  assign hist_d = {hist_q[0], rxd_s};
  assign bit_s  = (hist_q[1] & hist_q[0]) | (hist_q[1] & rxd_s) | (hist_q[0] & rxd_s);
  always_ff @(posedge clk) begin
    if (reset) hist_q <= 2'b11;
    else       hist_q <= hist_d;
  end
`else
  assign bit_s = rxd_s;
`endif

  always_comb begin
    sync_d  = {sync_q[0], rx.uart_rxd};
    prev_d  = rxd_s;
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    idx_d   = idx_q;
    stop_d  = stop_q;
    sr_d    = sr_q;
    data_d  = data_q;
    valid_d = 1'b0;
    brk_d   = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        // Needs a prior high sample, so a stuck-low line cannot retrigger.
        if (rx.uart_rx_en && prev_q && !rxd_s) state_d = START;
      end
      START: begin
        if (cnt_q == CNT_W'(START_AT)) begin
          if (!bit_s) begin
            state_d = DATA;
            cnt_d   = '0;
            idx_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (cnt_q == CNT_W'(BIT_AT)) begin
          sr_d[idx_q] = bit_s;
          cnt_d       = '0;
          idx_d       = idx_q + IDX_W'(1);
          if (idx_q == IDX_W'(PAYLOAD_BITS - 1)) begin
            state_d = STOP;
            stop_d  = '0;
          end
        end
      end
      STOP: begin
        if (cnt_q == CNT_W'(BIT_AT)) begin
          cnt_d = '0;
          if (!bit_s) begin
            brk_d   = (sr_q == '0);
            state_d = IDLE;
          end else if (stop_q == SB_W'(STOP_BITS - 1)) begin
            valid_d = 1'b1;
            data_d  = sr_q;
            state_d = IDLE;
          end else begin
            stop_d = stop_q + SB_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (!rx.uart_rx_en) begin
      state_d = IDLE;
      cnt_d   = '0;
      idx_d   = '0;
      stop_d  = '0;
      valid_d = 1'b0;
      brk_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q  <= 2'b11;
      prev_q  <= 1'b1;
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      stop_q  <= '0;
      sr_q    <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      brk_q   <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      prev_q  <= prev_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      stop_q  <= stop_d;
      sr_q    <= sr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      brk_q   <= brk_d;
    end
  end

  assign rx.uart_rx_valid = valid_q;
  assign rx.uart_rx_break = brk_q;
  assign rx.uart_rx_data  = data_q;
endmodule

// File: tb/tb_uart_rx_unit.sv
// Directed bench for uart_rx_unit at 16 clocks per bit.
module tb_uart_rx_unit;
  localparam int C = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  uart_rx_if #(.PAYLOAD_BITS(8)) rx ();

  uart_rx_unit #(
    .BIT_RATE(1000000), .CLK_HZ(16000000), .PAYLOAD_BITS(8), .STOP_BITS(1)
  ) dut (
    .clk(clk), .reset(reset), .rx(rx)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor: counts strobes, logs received bytes, tracks longest pulse run.
  int vcnt = 0, bcnt = 0, vrun = 0, brun = 0, vmax = 0, bmax = 0, vcyc = 0;
  logic [7:0] rlog [0:63];
  always @(negedge clk) begin
    if (rx.uart_rx_valid) begin
      vcnt <= vcnt + 1;
      rlog[vcnt[5:0]] <= rx.uart_rx_data;
      vcyc <= cyc;
    end
    vrun <= rx.uart_rx_valid ? vrun + 1 : 0;
    if (rx.uart_rx_valid && (vrun + 1 > vmax)) vmax <= vrun + 1;
    if (rx.uart_rx_break) bcnt <= bcnt + 1;
    brun <= rx.uart_rx_break ? brun + 1 : 0;
    if (rx.uart_rx_break && (brun + 1 > bmax)) bmax <= brun + 1;
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drive(input logic lvl, input int n);
    rx.uart_rxd = lvl;
    tick(n);
  endtask

  task automatic send(input logic [7:0] b);
    drive(1'b0, C);
    for (int i = 0; i < 8; i++) drive(b[i], C);
    drive(1'b1, C);
  endtask

  logic [7:0] bts [5] = '{8'h12, 8'hFE, 8'h00, 8'h80, 8'h7F};
  int vb, bb, t0;

  initial begin
    reset = 1'b1;
    rx.uart_rxd = 1'b1;
    rx.uart_rx_en = 1'b1;
    tick(3);
    chk("rst_valid", {31'd0, rx.uart_rx_valid}, 32'd0);
    chk("rst_break", {31'd0, rx.uart_rx_break}, 32'd0);
    chk("rst_data", {24'd0, rx.uart_rx_data}, 32'h00);
    reset = 1'b0;
    tick(2 * C);

    // single byte, pulse width and latency
    vb = vcnt; bb = bcnt; t0 = cyc;
    send(8'hA5);
    tick(4);
    chk("a5_count", vcnt - vb, 1);
    chk("a5_data", {24'd0, rlog[vb[5:0]]}, 32'hA5);
    chk("a5_out", {24'd0, rx.uart_rx_data}, 32'hA5);
    chk("a5_break", bcnt - bb, 0);
    chk("a5_width", vmax, 1);
    chk("a5_latency", {31'd0, (vcyc - t0 >= 150) && (vcyc - t0 <= 160)}, 1);

    // back-to-back frames, no idle gap
    vb = vcnt;
    for (int i = 0; i < 5; i++) send(bts[i]);
    tick(C);
    chk("b2b_count", vcnt - vb, 5);
    for (int i = 0; i < 5; i++)
      chk($sformatf("b2b_byte%0d", i), {24'd0, rlog[(vb + i) % 64]}, {24'd0, bts[i]});

    // long idle holds data
    send(8'h3C);
    tick(4);
    vb = vcnt;
    tick(65600);
    chk("idle_data", {24'd0, rx.uart_rx_data}, 32'h3C);
    chk("idle_valid", vcnt - vb, 0);
    send(8'hC3);
    tick(4);
    chk("c3_count", vcnt - vb, 1);
    chk("c3_data", {24'd0, rx.uart_rx_data}, 32'hC3);

    // break: line low for 12 bit times
    vb = vcnt; bb = bcnt;
    drive(1'b0, 12 * C);
    drive(1'b1, 2 * C);
    chk("brk_count", bcnt - bb, 1);
    chk("brk_width", bmax, 1);
    chk("brk_valid", vcnt - vb, 0);
    chk("brk_data", {24'd0, rx.uart_rx_data}, 32'hC3);

    // short glitch rejected, then a good frame
    vb = vcnt; bb = bcnt;
    drive(1'b0, 3);
    drive(1'b1, 2 * C);
    chk("glitch_valid", vcnt - vb, 0);
    chk("glitch_break", bcnt - bb, 0);
    send(8'h55);
    tick(4);
    chk("g55_count", vcnt - vb, 1);
    chk("g55_data", {24'd0, rx.uart_rx_data}, 32'h55);

    // full frame while disabled is ignored
    vb = vcnt;
    rx.uart_rx_en = 1'b0;
    send(8'h5A);
    tick(C);
    rx.uart_rx_en = 1'b1;
    chk("dis_valid", vcnt - vb, 0);
    chk("dis_data", {24'd0, rx.uart_rx_data}, 32'h55);

    // enable dropped mid-frame
    vb = vcnt; bb = bcnt;
    drive(1'b0, C); drive(1'b1, C); drive(1'b0, 2 * C);
    rx.uart_rx_en = 1'b0;
    rx.uart_rxd = 1'b1;
    tick(1);
    rx.uart_rx_en = 1'b1;
    tick(12 * C);
    chk("en_abort_valid", vcnt - vb, 0);
    chk("en_abort_break", bcnt - bb, 0);
    chk("en_abort_data", {24'd0, rx.uart_rx_data}, 32'h55);
    send(8'h81);
    tick(4);
    chk("en_81_data", {24'd0, rx.uart_rx_data}, 32'h81);
    chk("en_81_count", vcnt - vb, 1);

    // reset asserted mid-frame
    vb = vcnt;
    drive(1'b0, C); drive(1'b1, C); drive(1'b0, C);
    reset = 1'b1;
    rx.uart_rxd = 1'b1;
    tick(1);
    reset = 1'b0;
    chk("rst_mid_data", {24'd0, rx.uart_rx_data}, 32'h00);
    tick(12 * C);
    chk("rst_mid_valid", vcnt - vb, 0);
    send(8'h81);
    tick(4);
    chk("rst_81_data", {24'd0, rx.uart_rx_data}, 32'h81);
    chk("rst_81_count", vcnt - vb, 1);
    chk("final_vwidth", vmax, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
